// File: rtl/fc_mac_core.sv
// Sequential multiply-accumulate core for a small fully connected layer.
// Feature/weight/bias buffers are loaded in IDLE; one MAC per clock, results read back combinationally.
module fc_mac_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned N_IN       = 4,
    parameter int unsigned N_OUT      = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              x_wr_en,
    input  logic [$clog2(N_IN)-1:0]           x_wr_addr,
    input  logic [DATA_WIDTH-1:0]             x_wr_data,
    input  logic                              w_wr_en,
    input  logic [$clog2(N_IN*N_OUT)-1:0]     w_wr_addr,
    input  logic [DATA_WIDTH-1:0]             w_wr_data,
    input  logic                              b_wr_en,
    input  logic [$clog2(N_OUT)-1:0]          b_wr_addr,
    input  logic [ACC_WIDTH-1:0]              b_wr_data,
    input  logic                              relu_en,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    input  logic [$clog2(N_OUT)-1:0]          y_rd_addr,
    output logic [ACC_WIDTH-1:0]              y_rd_data
);

    localparam int unsigned XAW = $clog2(N_IN);
    localparam int unsigned WAW = $clog2(N_IN * N_OUT);
    localparam int unsigned YAW = $clog2(N_OUT);
    localparam int unsigned PW  = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_STORE
    } state_t;

    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] x_q [N_IN];
    logic signed [DATA_WIDTH-1:0] w_q [N_IN*N_OUT];
    logic signed [ACC_WIDTH-1:0]  b_q [N_OUT];
    logic signed [ACC_WIDTH-1:0]  y_q [N_OUT];

    logic [XAW-1:0]              i_q;
    logic [YAW-1:0]              j_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic                        relu_q;
    logic                        busy_q;
    logic                        done_q;

    logic                        start_run;
    logic                        mac_step;
    logic                        store_y;
    logic                        last_i;
    logic                        last_j;
    logic                        wr_ok;
    logic [WAW-1:0]              w_idx;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] b_first;

    assign busy   = busy_q;
    assign done   = done_q;
    assign wr_ok  = (state_q == S_IDLE);
    assign last_i = (i_q == XAW'(N_IN - 1));
    assign last_j = (j_q == YAW'(N_OUT - 1));

    assign w_idx = WAW'(j_q) * WAW'(N_IN) + WAW'(i_q);
    assign prod  = PW'(x_q[i_q]) * PW'(w_q[w_idx]);

    // A bias write in the same cycle as start must seed the first accumulation.
    assign b_first = (b_wr_en && wr_ok && (b_wr_addr == '0)) ? b_wr_data : b_q[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        mac_step  = 1'b0;
        store_y   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_d   = S_MAC;
                end
            end
            S_MAC: begin
                mac_step = 1'b1;
                if (last_i) state_d = S_STORE;
            end
            S_STORE: begin
                store_y = 1'b1;
                state_d = last_j ? S_IDLE : S_MAC;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < N_IN; k++)         x_q[k] <= '0;
            for (int unsigned k = 0; k < N_IN * N_OUT; k++) w_q[k] <= '0;
            for (int unsigned k = 0; k < N_OUT; k++) begin
                b_q[k] <= '0;
                y_q[k] <= '0;
            end
            i_q    <= '0;
            j_q    <= '0;
            acc_q  <= '0;
            relu_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // Host writes land only while idle; unmatched addresses fall through.
            if (wr_ok) begin
                for (int unsigned k = 0; k < N_IN; k++)
                    if (x_wr_en && (x_wr_addr == XAW'(k))) x_q[k] <= x_wr_data;
                for (int unsigned k = 0; k < N_IN * N_OUT; k++)
                    if (w_wr_en && (w_wr_addr == WAW'(k))) w_q[k] <= w_wr_data;
                for (int unsigned k = 0; k < N_OUT; k++)
                    if (b_wr_en && (b_wr_addr == YAW'(k))) b_q[k] <= b_wr_data;
            end

            if (start_run) begin
                i_q    <= '0;
                j_q    <= '0;
                acc_q  <= b_first;
                relu_q <= relu_en;
                busy_q <= 1'b1;
                done_q <= 1'b0;
            end

            if (mac_step) begin
                acc_q <= acc_q + ACC_WIDTH'(prod);
                i_q   <= i_q + XAW'(1);
            end

            if (store_y) begin
                y_q[j_q] <= (relu_q && acc_q[ACC_WIDTH-1]) ? '0 : acc_q;
                i_q      <= '0;
                if (last_j) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    j_q   <= j_q + YAW'(1);
                    acc_q <= b_q[j_q + YAW'(1)];
                end
            end
        end
    end

    always_comb begin
        y_rd_data = '0;
        for (int unsigned k = 0; k < N_OUT; k++)
            if (y_rd_addr == YAW'(k)) y_rd_data = y_q[k];
    end

endmodule

// File: doc/fc_mac_core.md
# fc_mac_core

Compute core of the Fully_Connected_1 AXI4-Lite peripheral. Sits directly downstream of the AXI4-Lite slave register bank: the bank forwards feature, weight and bias writes and a start pulse, the core performs a sequential multiply-accumulate for a small fully connected layer, and the bank reads results and status back. One MAC per clock, no external memory.

## Interface

Parameters:
- DATA_WIDTH, 8, width of signed feature and weight operands
- ACC_WIDTH, 32, width of signed bias, accumulator and result
- N_IN, 4, number of input features
- N_OUT, 4, number of output neurons

Ports:
- clock  in  1  single clock for all state
- reset  in  1  asynchronous, active-high; clears all state
- x_wr_en  in  1  write feature buffer
- x_wr_addr  in  clog2(N_IN)  feature index
- x_wr_data  in  DATA_WIDTH  signed feature value
- w_wr_en  in  1  write weight buffer
- w_wr_addr  in  clog2(N_IN*N_OUT)  weight index = j*N_IN + i
- w_wr_data  in  DATA_WIDTH  signed weight value
- b_wr_en  in  1  write bias buffer
- b_wr_addr  in  clog2(N_OUT)  bias index
- b_wr_data  in  ACC_WIDTH  signed bias value
- relu_en  in  1  apply ReLU to results; sampled on accepted start
- start  in  1  single-cycle start request
- busy  out  1  computation in progress
- done  out  1  sticky completion flag
- y_rd_addr  in  clog2(N_OUT)  result index
- y_rd_data  out  ACC_WIDTH  result[y_rd_addr], combinational read

## Operation

- Buffers: x[N_IN], w[N_IN*N_OUT], b[N_OUT], y[N_OUT]; all registers, all zero on reset.
- Writes accepted only when state is IDLE; any write while busy is dropped. Out-of-range addresses (non-power-of-two sizes) dropped.
- FSM states: IDLE, MAC, STORE.
  - IDLE: start=1 -> MAC, j=0, i=0, acc=b[0], latch relu_en, busy=1, done=0.
  - MAC: acc += sext(x[i]*w[j*N_IN+i]); i increments; after i=N_IN-1 -> STORE.
  - STORE: y[j] = (relu && acc<0) ? 0 : acc. If j=N_OUT-1 -> IDLE, busy=0, done=1; else j++, i=0, acc=b[j+1] -> MAC.
- start while busy ignored. start in IDLE with done=1 clears done and restarts.
- Arithmetic: product 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH; accumulation modulo 2^ACC_WIDTH (two's-complement wrap, no saturation). ACC_WIDTH >= 2*DATA_WIDTH required.
- y holds previous results until overwritten by its own STORE; during a run y[k] for k<j is already new.

## Timing

- Reset values: busy=0, done=0, y_rd_data=0 (all y cleared), state IDLE.
- start sampled at rising edge E; busy=1 after E; busy falls and done rises at edge E + N_OUT*(N_IN+1). Default: 20 cycles.
- Buffer writes take effect at the same edge; a write at edge E-1 is visible to a start at edge E.
- Write and start in the same IDLE cycle: write is applied, computation uses the new value (write precedes first MAC read).
- y_rd_data zero-latency from y_rd_addr and y registers.
- Reset asserted mid-run: immediate return to IDLE, busy=0, done=0, all buffers and results zeroed; no partial result retained.

## Test plan

- Identity weights (w[j*4+j]=1, others 0), x={1,2,3,4}, b=0, start -> busy exactly 20 cycles, done=1, y={1,2,3,4}.
- x={-128,-128,-128,-128}, all w=-128, b={0,1,-1,100}, relu_en=0 -> y={65536,65537,65535,65636}.
- w row j all 1, x={-5,2,0,1}, b={0,0,10,-3}, relu_en=1 -> y={0,0,8,0}; same with relu_en=0 -> y={-2,-2,8,-5}.
- During run: start pulse and x_wr_en(addr 0, 7) -> busy still ends at cycle 20, results unchanged, x[0] unchanged after done.
- Reset asserted 7 cycles after start -> busy=0, done=0, y_rd_data=0 for all addresses; new start with zero buffers -> y=0 after 20 cycles.
- Back-to-back: start on the cycle after done rises with new x -> done cleared next edge, new results after 20 more cycles.
